// File: rtl/pwm_pkg.sv
// Shared constants for the multi-channel PWM block: cfg register map,
// mode bit positions and the centre-aligned count direction.
package pwm_pkg;

    // cfg register map: period, mode, then one duty register per channel
    localparam int ADDR_PERIOD    = 0;
    localparam int ADDR_MODE      = 1;
    localparam int ADDR_DUTY_BASE = 2;

    // mode register bits
    localparam int MODE_CENTER = 0;
    localparam int MODE_INV    = 1;

    // Count direction (only meaningful in centre-aligned mode)
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/pwm_timebase.sv
// Shared period counter. Handles the zero-period clamp, edge/centre counting,
// commit-point detection and the registered period_end pulse.
// The commit strobe is combinational and marks the last cycle of a PWM cycle;
// the parent loads its active registers on that same edge.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             centre,
    input  logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] cnt,
    output logic             commit,
    output logic             period_end
);

    dir_e             dir, dir_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] pe;
    logic [CNT_W-1:0] pe_m1;

    // A programmed period of 0 behaves like a period of 1
    assign pe    = (period == '0) ? CNT_W'(1) : period;
    assign pe_m1 = pe - CNT_W'(1);

    // Counter and direction registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            dir        <= DIR_UP;
            period_end <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            dir        <= dir_nxt;
            period_end <= commit;
        end
    end

    // Next count, direction and commit detection; every commit restarts
    // from 0 counting up so a mode change always begins a clean cycle.
    always_comb begin
        commit  = 1'b0;
        cnt_nxt = cnt;
        dir_nxt = dir;
        if (!en) begin
            cnt_nxt = '0;
            dir_nxt = DIR_UP;
        end else if (!centre) begin
            if (cnt >= pe_m1) begin
                commit  = 1'b1;
                cnt_nxt = '0;
                dir_nxt = DIR_UP;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end else if (dir == DIR_UP) begin
            if (cnt >= pe_m1) begin
                if (pe_m1 <= CNT_W'(1)) begin
                    // Pe of 1 or 2: there is no down leg, the top is the end
                    commit  = 1'b1;
                    cnt_nxt = '0;
                    dir_nxt = DIR_UP;
                end else begin
                    cnt_nxt = pe_m1 - CNT_W'(1);
                    dir_nxt = DIR_DOWN;
                end
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end else begin
            if (cnt <= CNT_W'(1)) begin
                commit  = 1'b1;
                cnt_nxt = '0;
                dir_nxt = DIR_UP;
            end else begin
                cnt_nxt = cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// CH-channel PWM generator. cfg writes land in shadow registers; the active
// copies load at each commit point (or continuously while disabled), so a
// new configuration only ever takes effect at a cycle boundary.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter  int CH         = 4,
    parameter  int CNT_W      = 16,
    parameter  int PERIOD_RST = 500,
    parameter  int DUTY_RST   = 50,
    localparam int ADDR_W     = $clog2(CH + 2)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [CNT_W-1:0]  cfg_wdata,
    output logic [CH-1:0]     pwm_out,
    output logic              period_end
);

    logic [CNT_W-1:0] period_sh, period_sh_nxt, period_act;
    logic [1:0]       mode_sh, mode_sh_nxt, mode_act;
    logic [CNT_W-1:0] duty_sh     [CH];
    logic [CNT_W-1:0] duty_sh_nxt [CH];
    logic [CNT_W-1:0] duty_act    [CH];
    logic [CNT_W-1:0] cnt;
    logic             commit;
    logic             load;
    logic [CH-1:0]    cmp;

    pwm_timebase #(
        .CNT_W (CNT_W)
    ) u_timebase (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .centre     (mode_act[MODE_CENTER]),
        .period     (period_act),
        .cnt        (cnt),
        .commit     (commit),
        .period_end (period_end)
    );

    // Shadow next values include this cycle's write, so a write on the
    // commit cycle is carried by that commit. Unmapped addresses match nothing.
    always_comb begin
        period_sh_nxt = period_sh;
        mode_sh_nxt   = mode_sh;
        for (int i = 0; i < CH; i++) begin
            duty_sh_nxt[i] = duty_sh[i];
        end
        if (cfg_we) begin
            if (cfg_addr == ADDR_W'(ADDR_PERIOD)) begin
                period_sh_nxt = cfg_wdata;
            end
            if (cfg_addr == ADDR_W'(ADDR_MODE)) begin
                mode_sh_nxt = cfg_wdata[1:0];
            end
            for (int i = 0; i < CH; i++) begin
                if (cfg_addr == ADDR_W'(ADDR_DUTY_BASE + i)) begin
                    duty_sh_nxt[i] = cfg_wdata;
                end
            end
        end
    end

    assign load = commit | ~en;

    // Shadow and active configuration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_sh  <= CNT_W'(PERIOD_RST);
            period_act <= CNT_W'(PERIOD_RST);
            mode_sh    <= '0;
            mode_act   <= '0;
            for (int i = 0; i < CH; i++) begin
                duty_sh[i]  <= CNT_W'(DUTY_RST);
                duty_act[i] <= CNT_W'(DUTY_RST);
            end
        end else begin
            period_sh <= period_sh_nxt;
            mode_sh   <= mode_sh_nxt;
            for (int i = 0; i < CH; i++) begin
                duty_sh[i] <= duty_sh_nxt[i];
            end
            if (load) begin
                period_act <= period_sh_nxt;
                mode_act   <= mode_sh_nxt;
                for (int i = 0; i < CH; i++) begin
                    duty_act[i] <= duty_sh_nxt[i];
                end
            end
        end
    end

    // One comparator per channel against the shared counter
    for (genvar g = 0; g < CH; g++) begin : g_cmp
        assign cmp[g] = (cnt < duty_act[g]);
    end

    // Registered outputs; idle level while disabled is the inactive level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out <= '0;
        end else if (!en) begin
            pwm_out <= {CH{mode_act[MODE_INV]}};
        end else begin
            pwm_out <= cmp ^ {CH{mode_act[MODE_INV]}};
        end
    end

endmodule
